// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-addressed memory port, sub-word stores via a one-stall read-modify-write.
// Define LSU_STATS_EN to add the stat_* event counters and the CNT_W parameter.
module load_store_unit #(
  parameter int WIDTH = 32
`ifdef LSU_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             fault,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
`ifdef LSU_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_loads,
  output logic [CNT_W-1:0] stat_stores,
  output logic [CNT_W-1:0] stat_rmw_stalls,
  output logic [CNT_W-1:0] stat_faults
`endif
);

  typedef enum logic {IDLE, MERGE_WR} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] merge_q;
  logic [WIDTH-1:0] addr_q;

  logic is_byte, is_half, is_word;
  logic illegal, misaligned, active;
  logic do_load, do_sw, do_rmw;

  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3 == 3'b010);

  // 011, 11x and the unsigned encodings used as stores are all illegal.
  assign illegal    = (funct3 == 3'b011) | (funct3[2] & (funct3[1] | req_we));
  assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign active     = !rst && req_valid && (state_reg == IDLE);

  assign fault   = active && (illegal || misaligned);
  assign do_load = active && !(illegal || misaligned) && !req_we;
  assign do_sw   = active && !(illegal || misaligned) && req_we && is_word;
  assign do_rmw  = active && !(illegal || misaligned) && req_we && !is_word;

  logic [7:0]       rd_byte    [4];
  logic [7:0]       merge_byte [4];
  logic [WIDTH-1:0] merge_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic hit;
      assign rd_byte[gi]    = mem_rd[8*gi +: 8];
      assign hit            = is_byte ? (addr[1:0] == 2'(gi)) : (addr[1] == (gi >= 2));
      assign merge_byte[gi] = !hit ? rd_byte[gi] : (is_byte ? wdata[7:0] : wdata[8*(gi%2) +: 8]);
    end
  endgenerate

  assign merge_word = {merge_byte[3], merge_byte[2], merge_byte[1], merge_byte[0]};

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_byte[addr[1:0]];
  assign half_sel = addr[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    rdata = '0;
    if (do_load) begin
      case (funct3)
        3'b000:  rdata = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
        3'b001:  rdata = {{(WIDTH-16){half_sel[15]}}, half_sel};
        3'b010:  rdata = mem_rd;
        3'b100:  rdata = {{(WIDTH-8){1'b0}}, byte_sel};
        3'b101:  rdata = {{(WIDTH-16){1'b0}}, half_sel};
        default: rdata = '0;
      endcase
    end
  end

  assign stall    = do_rmw;
  assign mem_we   = do_sw || ((state_reg == MERGE_WR) && !rst);
  assign mem_addr = (state_reg == MERGE_WR) ? addr_q : {addr[WIDTH-1:2], 2'b00};
  assign mem_wd   = (state_reg == MERGE_WR) ? merge_q : wdata;

  // Merge is captured in a register so mem_wd never depends combinationally on mem_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      merge_q   <= '0;
      addr_q    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_rmw) begin
            addr_q    <= {addr[WIDTH-1:2], 2'b00};
            merge_q   <= merge_word;
            state_reg <= MERGE_WR;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads      <= '0;
      stat_stores     <= '0;
      stat_rmw_stalls <= '0;
      stat_faults     <= '0;
    end else begin
      stat_loads      <= stat_loads + CNT_W'(do_load);
      stat_stores     <= stat_stores + CNT_W'(mem_we);
      stat_rmw_stalls <= stat_rmw_stalls + CNT_W'(stall);
      stat_faults     <= stat_faults + CNT_W'(fault);
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a word-level reference memory model.
// Works with or without LSU_STATS_EN defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wd, mem_rd;
  logic        stall, fault, mem_we;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_rmw_stalls, stat_faults;
`endif

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores),
    .stat_rmw_stalls(stat_rmw_stalls), .stat_faults(stat_faults)
`endif
  );

  // Environment memory: async read, sync write, preloaded through the same port.
  logic [31:0] env_mem [256];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  assign mem_rd = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_en) env_mem[pre_idx] <= pre_val;
    else if (mem_we) env_mem[mem_addr[9:2]] <= mem_wd;
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int n_loads, n_stores, n_stalls, n_faults;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit legal;
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    if (!legal) return 1'b1;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] f3);
    logic [31:0] sh, b, h;
    sh = word >> (8 * a[1:0]);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [31:0] a,
                                              input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
    return (word & ~(mask << (8 * a[1:0]))) | ((wd & mask) << (8 * a[1:0]));
  endfunction

  // Per-cycle expectations consumed by the compare process.
  bit          chk_en = 1'b0;
  bit          chk_rdata, chk_addr, chk_wd;
  logic        exp_stall, exp_fault, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wd;
  string       cur = "";

  always @(negedge clk) begin
    if (chk_en) begin
      check({cur, "/stall"}, {31'd0, stall}, {31'd0, exp_stall});
      check({cur, "/fault"}, {31'd0, fault}, {31'd0, exp_fault});
      check({cur, "/mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
      if (chk_rdata) check({cur, "/rdata"}, rdata, exp_rdata);
      if (chk_addr)  check({cur, "/mem_addr"}, mem_addr, exp_addr);
      if (chk_wd)    check({cur, "/mem_wd"}, mem_wd, exp_wd);
    end
  end

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_fault = 1'b0; exp_we = 1'b0; exp_rdata = '0;
    exp_addr = '0; exp_wd = '0;
    chk_rdata = 1'b1; chk_addr = 1'b0; chk_wd = 1'b0;
  endtask

  // One core request; sub-word stores span two cycles. Returns at the negedge of the last cycle.
  task automatic run_txn(input string nm, input bit v, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit rst_in_merge);
    logic [31:0] w;
    logic [7:0]  idx;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
    idx = a[9:2];
    w   = ref_mem[idx];
    cur = nm;
    set_idle_exp();
    chk_addr = 1'b1;
    exp_addr = a & ~32'd3;
    chk_en   = 1'b1;
    if (!v) begin
    end else if (model_fault(we, f3, a)) begin
      exp_fault = 1'b1;
      n_faults++;
    end else if (!we) begin
      exp_rdata = model_load(w, a, f3);
      n_loads++;
    end else if (f3 == 3'd2) begin
      exp_we = 1'b1; chk_wd = 1'b1; exp_wd = wd; chk_rdata = 1'b0;
      ref_mem[idx] = wd;
      n_stores++;
    end else begin
      exp_stall = 1'b1; chk_rdata = 1'b0;
      n_stalls++;
      @(negedge clk);
      @(posedge clk); #1;
      // The unit ignores request inputs in the write cycle.
      req_valid = 1'($urandom); req_we = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      set_idle_exp();
      if (rst_in_merge) begin
        rst = 1'b1;
        n_loads = 0; n_stores = 0; n_stalls = 0; n_faults = 0;
      end else begin
        exp_we = 1'b1; chk_addr = 1'b1; chk_wd = 1'b1; chk_rdata = 1'b0;
        exp_addr = a & ~32'd3;
        exp_wd = model_merge(w, a, f3, wd);
        ref_mem[idx] = exp_wd;
        n_stores++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2;
    addr = 32'h8; wdata = 32'hDEADBEEF;
    pre_en = 1'b1; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 16; i++) begin
      pre_idx = 8'(i);
      case (i)
        0:       pre_val = 32'h80FF7F01;
        1:       pre_val = 32'h12345678;
        2:       pre_val = 32'h11223344;
        default: pre_val = $urandom;
      endcase
      ref_mem[i] = pre_val;
      @(posedge clk); #1;
    end
    pre_en = 1'b0;

    // Reset holds every output low even with a store presented.
    cur = "reset";
    set_idle_exp();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    n_loads = 0; n_stores = 0; n_stalls = 0; n_faults = 0;

    run_txn("sb_9", 1, 1, 3'd0, 32'h9, 32'h000000AB, 0);
    check("sb_9_wd", mem_wd, 32'h1122AB44);
    check("sb_9_addr", mem_addr, 32'h8);
    run_txn("lw_8", 1, 0, 3'd2, 32'h8, 32'h0, 0);
    check("lw_8_lit", rdata, 32'h1122AB44);

    run_txn("lb_a802", 1, 0, 3'd0, 32'hA802, 32'h0, 0);
    check("lb_lit", rdata, 32'hFFFFFFFF);
    run_txn("lbu_a802", 1, 0, 3'd4, 32'hA802, 32'h0, 0);
    check("lbu_lit", rdata, 32'h000000FF);
    run_txn("lhu_a802", 1, 0, 3'd5, 32'hA802, 32'h0, 0);
    check("lhu_lit", rdata, 32'h000080FF);
    run_txn("lh_a802", 1, 0, 3'd1, 32'hA802, 32'h0, 0);
    check("lh_lit", rdata, 32'hFFFF80FF);

    run_txn("sh_6", 1, 1, 3'd1, 32'h6, 32'h0000BEEF, 0);
    run_txn("lw_4", 1, 0, 3'd2, 32'h4, 32'h0, 0);
    check("sh_6_lit", rdata, 32'hBEEF5678);

    run_txn("sw_6", 1, 1, 3'd2, 32'h6, 32'hCAFEF00D, 0);
    check("sw_6_fault", {31'd0, fault}, 32'd1);
    run_txn("lw_4_after", 1, 0, 3'd2, 32'h4, 32'h0, 0);
    check("sw_6_nowrite", rdata, 32'hBEEF5678);
    run_txn("lw_1", 1, 0, 3'd2, 32'h1, 32'h0, 0);
    check("lw_1_rdata", rdata, 32'h0);
    run_txn("f3_011", 1, 0, 3'd3, 32'h0, 32'h0, 0);
    check("f3_011_fault", {31'd0, fault}, 32'd1);

    run_txn("sb_rst", 1, 1, 3'd0, 32'h8, 32'h000000CD, 1);
    run_txn("idle_after_rst", 0, 0, 3'd0, 32'h8, 32'h0, 0);
    run_txn("lw_8_rst", 1, 0, 3'd2, 32'h8, 32'h0, 0);
    check("rst_nowrite", rdata, 32'h1122AB44);

    for (int i = 0; i < 400; i++) begin
      run_txn("rand", ($urandom_range(0, 9) != 0), 1'($urandom), 3'($urandom),
              32'($urandom_range(0, 63)), $urandom, ($urandom_range(0, 39) == 0));
    end

`ifdef LSU_STATS_EN
    run_txn("stats_sync", 0, 0, 3'd0, 32'h0, 32'h0, 0);
    check("stat_loads", stat_loads, 32'(n_loads));
    check("stat_stores", stat_stores, 32'(n_stores));
    check("stat_rmw_stalls", stat_rmw_stalls, 32'(n_stalls));
    check("stat_faults", stat_faults, 32'(n_faults));
`endif

    chk_en = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
